// File: rtl/wb_pkg.sv
// Shared types for the write-back queue: pipe-select encodings, default widths
// and the queue entry record. The scoreboard uses the same pipe encodings.
package wb_pkg;

    localparam int W_PA_REG_D    = 5;
    localparam int W_PD_DATA_D   = 32;
    localparam int W_PC_SEL_WB_D = 2;
    localparam int S_AMT_ENT_D   = 4;
    localparam int W_PTR_D       = 2;

    localparam logic [1:0] V_unpip = 2'b00;
    localparam logic [1:0] V_pip0  = 2'b01;
    localparam logic [1:0] V_pip1  = 2'b10;

    typedef struct packed {
        logic                   valid;
        logic [W_PA_REG_D-1:0]  addr;
        logic [W_PD_DATA_D-1:0] data;
    } wb_ent_t;

endpackage

// File: rtl/wb_cam_match.sv
// Bypass lookup over the queued entries; returns the youngest matching entry.
// Only built when WB_BYPASS_EN is defined.
`ifdef WB_BYPASS_EN
module wb_cam_match
    import wb_pkg::*;
#(
    parameter int S_amt_ent = S_AMT_ENT_D,
    parameter int W_ptr     = W_PTR_D
) (
    input  wb_ent_t [S_amt_ent-1:0]  i_ent,
    input  logic    [W_ptr-1:0]      i_rdptr,
    input  logic    [W_PA_REG_D-1:0] i_addr,
    output logic                     o_hit,
    output logic    [W_PD_DATA_D-1:0] o_data
);

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [W_ptr-1:0] w_idx;
        w_idx  = '0;
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < S_amt_ent; i++) begin
            w_idx = i_rdptr + W_ptr'(i);
            if (i_ent[w_idx].valid && (i_ent[w_idx].addr == i_addr) &&
                (i_addr != {W_PA_REG_D{1'b0}})) begin
                o_hit  = 1'b1;
                o_data = i_ent[w_idx].data;
            end else begin
                o_hit  = o_hit;
            end
        end
    end

endmodule
`endif

// File: rtl/wb_queue.sv
// In-order write-back queue between the scoreboard and the register-file write
// port. Optional operand bypass from queued entries under WB_BYPASS_EN.
module wb_queue
    import wb_pkg::*;
#(
    parameter int W_PA_REG    = W_PA_REG_D,
    parameter int W_PD_DATA   = W_PD_DATA_D,
    parameter int W_PC_SEL_WB = W_PC_SEL_WB_D,
    parameter int S_amt_ent   = S_AMT_ENT_D,
    parameter int W_ptr       = W_PTR_D
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W_PA_REG-1:0]    CDI_PC_rd,
    input  logic [W_PC_SEL_WB-1:0] CDI_PC_selwb,
    input  logic [W_PD_DATA-1:0]   CDI_PD_res0,
    input  logic [W_PD_DATA-1:0]   CDI_PD_res1,
    input  logic                   CFI_PC_clear,
    input  logic                   CFI_PC_rfbusy,
    output logic                   CDO_PC_rfwe,
    output logic [W_PA_REG-1:0]    CDO_PA_rfwa,
    output logic [W_PD_DATA-1:0]   CDO_PD_rfwd,
    output logic                   CDO_PC_full,
    output logic                   CDO_PC_ovf
`ifdef WB_BYPASS_EN
    ,
    input  logic [W_PA_REG-1:0]    CDI_PA_rs0,
    input  logic [W_PA_REG-1:0]    CDI_PA_rs1,
    output logic                   CDO_PC_hit0,
    output logic                   CDO_PC_hit1,
    output logic [W_PD_DATA-1:0]   CDO_PD_byp0,
    output logic [W_PD_DATA-1:0]   CDO_PD_byp1
`endif
);

    localparam logic [W_ptr:0] C_depth = (W_ptr+1)'(S_amt_ent);

    wb_ent_t [S_amt_ent-1:0] r_ent;
    logic [W_ptr-1:0]        r_rdptr;
    logic [W_ptr-1:0]        r_wrptr;
    logic [W_ptr:0]          r_count;
    logic                    r_full;
    logic                    r_ovf;

    logic                    w_push_req;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_ovf;
    logic [W_PD_DATA-1:0]    w_res;
    logic [W_ptr:0]          w_count_nxt;
    wb_ent_t                 w_head;

    assign w_head = r_ent[r_rdptr];

    // Push/pop decisions; a push into a full queue only survives alongside a pop.
    always_comb begin
        w_push_req = 1'b0;
        w_res      = CDI_PD_res0;
        case (CDI_PC_selwb)
            V_pip0:  begin w_push_req = 1'b1; w_res = CDI_PD_res0; end
            V_pip1:  begin w_push_req = 1'b1; w_res = CDI_PD_res1; end
            default: begin w_push_req = 1'b0; w_res = CDI_PD_res0; end
        endcase
        if ((CDI_PC_rd == {W_PA_REG{1'b0}}) || CFI_PC_clear) begin
            w_push_req = 1'b0;
        end else begin
            w_push_req = w_push_req;
        end
        w_pop       = (r_count != {(W_ptr+1){1'b0}}) && !CFI_PC_rfbusy;
        w_push      = w_push_req && ((r_count != C_depth) || w_pop);
        w_ovf       = w_push_req && (r_count == C_depth) && !w_pop;
        w_count_nxt = r_count + (W_ptr+1)'(w_push) - (W_ptr+1)'(w_pop);
    end

    // Queue state; clearing the popped valid bit first lets a same-slot push win.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ent   <= '0;
            r_rdptr <= '0;
            r_wrptr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_ent[r_rdptr].valid <= 1'b0;
                r_rdptr              <= r_rdptr + W_ptr'(1);
            end
            if (w_push) begin
                r_ent[r_wrptr] <= '{valid: 1'b1, addr: CDI_PC_rd, data: w_res};
                r_wrptr        <= r_wrptr + W_ptr'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_depth);
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Write port: head entry whenever the port is free and the queue is not empty.
    always_comb begin
        if (w_pop && w_head.valid) begin
            CDO_PC_rfwe = 1'b1;
            CDO_PA_rfwa = w_head.addr;
            CDO_PD_rfwd = w_head.data;
        end else begin
            CDO_PC_rfwe = 1'b0;
            CDO_PA_rfwa = '0;
            CDO_PD_rfwd = '0;
        end
    end

    assign CDO_PC_full = r_full;
    assign CDO_PC_ovf  = r_ovf;

`ifdef WB_BYPASS_EN
    wb_cam_match #(.S_amt_ent(S_amt_ent), .W_ptr(W_ptr)) u_cam0 (
        .i_ent   (r_ent),
        .i_rdptr (r_rdptr),
        .i_addr  (CDI_PA_rs0),
        .o_hit   (CDO_PC_hit0),
        .o_data  (CDO_PD_byp0)
    );

    wb_cam_match #(.S_amt_ent(S_amt_ent), .W_ptr(W_ptr)) u_cam1 (
        .i_ent   (r_ent),
        .i_rdptr (r_rdptr),
        .i_addr  (CDI_PA_rs1),
        .o_hit   (CDO_PC_hit1),
        .o_data  (CDO_PD_byp1)
    );
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (bypass checks when WB_BYPASS_EN).
`timescale 1ns/1ps
module tb_wb_queue;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd;
    logic [1:0]  selwb;
    logic [31:0] res0;
    logic [31:0] res1;
    logic        clear;
    logic        rfbusy;
    logic        rfwe;
    logic [4:0]  rfwa;
    logic [31:0] rfwd;
    logic        full;
    logic        ovf;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic        hit0;
    logic        hit1;
    logic [31:0] byp0;
    logic [31:0] byp1;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    wb_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CDI_PC_rd     (rd),
        .CDI_PC_selwb  (selwb),
        .CDI_PD_res0   (res0),
        .CDI_PD_res1   (res1),
        .CFI_PC_clear  (clear),
        .CFI_PC_rfbusy (rfbusy),
        .CDO_PC_rfwe   (rfwe),
        .CDO_PA_rfwa   (rfwa),
        .CDO_PD_rfwd   (rfwd),
        .CDO_PC_full   (full),
        .CDO_PC_ovf    (ovf)
`ifdef WB_BYPASS_EN
        ,
        .CDI_PA_rs0    (rs0),
        .CDI_PA_rs1    (rs1),
        .CDO_PC_hit0   (hit0),
        .CDO_PC_hit1   (hit1),
        .CDO_PD_byp0   (byp0),
        .CDO_PD_byp1   (byp1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; selwb = 2'b00; rd = 5'd0; clear = 1'b0; rfbusy = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd = 5'd3; selwb = 2'b01; res0 = 32'h1234_5678; res1 = 32'h0;
        clear = 1'b0; rfbusy = 1'b0;
`ifdef WB_BYPASS_EN
        rs0 = 5'd0; rs1 = 5'd0;
`endif
        step();
        rst_n = 1'b1; selwb = 2'b00;
        n_chk++; if (rfwe !== 1'b0) $display("FAIL reset_rfwe got %h want 0", rfwe); else n_pass++;
        n_chk++; if (rfwa !== 5'd0) $display("FAIL reset_rfwa got %h want 0", rfwa); else n_pass++;
        n_chk++; if (rfwd !== 32'd0) $display("FAIL reset_rfwd got %h want 0", rfwd); else n_pass++;
        n_chk++; if (full !== 1'b0) $display("FAIL reset_full got %h want 0", full); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %h want 0", ovf); else n_pass++;
    endtask

    task automatic test_single_push();
        selwb = 2'b01; rd = 5'd3; res0 = 32'hA5A5_0001; res1 = 32'hDEAD_BEEF;
        step();
        selwb = 2'b00;
        n_chk++; if (rfwe !== 1'b1) $display("FAIL single_rfwe got %h want 1", rfwe); else n_pass++;
        n_chk++; if (rfwa !== 5'd3) $display("FAIL single_rfwa got %h want 3", rfwa); else n_pass++;
        n_chk++; if (rfwd !== 32'hA5A5_0001) $display("FAIL single_rfwd got %h want a5a50001", rfwd); else n_pass++;
        step();
        n_chk++; if (rfwe !== 1'b0) $display("FAIL single_empty got %h want 0", rfwe); else n_pass++;
    endtask

    task automatic test_filter();
        selwb = 2'b01; rd = 5'd0; res0 = 32'h1111_1111; step();
        n_chk++; if (rfwe !== 1'b0) $display("FAIL filter_rd0 got %h want 0", rfwe); else n_pass++;
        selwb = 2'b11; rd = 5'd7; step();
        n_chk++; if (rfwe !== 1'b0) $display("FAIL filter_sel11 got %h want 0", rfwe); else n_pass++;
        selwb = 2'b10; rd = 5'd7; res1 = 32'h2222_2222; clear = 1'b1; step();
        clear = 1'b0; selwb = 2'b00;
        n_chk++; if (rfwe !== 1'b0) $display("FAIL filter_clear got %h want 0", rfwe); else n_pass++;
        step();
        n_chk++; if (rfwe !== 1'b0) $display("FAIL filter_after got %h want 0", rfwe); else n_pass++;
        n_chk++; if (full !== 1'b0) $display("FAIL filter_full got %h want 0", full); else n_pass++;
    endtask

    task automatic test_backpressure();
        rfbusy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            selwb = 2'b10; rd = 5'(i); res1 = 32'h0000_0100 + 32'(i);
            step();
            if (i == 3) begin
                n_chk++; if (full !== 1'b0) $display("FAIL bp_full3 got %h want 0", full); else n_pass++;
            end
        end
        n_chk++; if (full !== 1'b1) $display("FAIL bp_full4 got %h want 1", full); else n_pass++;
        n_chk++; if (rfwe !== 1'b0) $display("FAIL bp_busy_rfwe got %h want 0", rfwe); else n_pass++;
        selwb = 2'b10; rd = 5'd5; res1 = 32'h0000_0105; step();
        selwb = 2'b00;
        n_chk++; if (ovf !== 1'b1) $display("FAIL bp_ovf got %h want 1", ovf); else n_pass++;
        n_chk++; if (full !== 1'b1) $display("FAIL bp_full5 got %h want 1", full); else n_pass++;
        rfbusy = 1'b0; #1;
        for (int i = 1; i <= 4; i++) begin
            n_chk++; if (rfwe !== 1'b1 || rfwa !== 5'(i) || rfwd !== 32'h0000_0100 + 32'(i))
                $display("FAIL bp_drain%0d got we=%h a=%h d=%h want we=1 a=%h d=%h",
                         i, rfwe, rfwa, rfwd, 5'(i), 32'h0000_0100 + 32'(i));
            else n_pass++;
            step();
        end
        n_chk++; if (rfwe !== 1'b0) $display("FAIL bp_discarded got %h want 0", rfwe); else n_pass++;
        n_chk++; if (full !== 1'b0) $display("FAIL bp_full_end got %h want 0", full); else n_pass++;
        n_chk++; if (ovf !== 1'b1) $display("FAIL bp_ovf_sticky got %h want 1", ovf); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [4:0] exp_a [4];
        exp_a[0] = 5'd2; exp_a[1] = 5'd3; exp_a[2] = 5'd4; exp_a[3] = 5'd9;
        do_reset();
        n_chk++; if (ovf !== 1'b0) $display("FAIL fpp_ovf_reset got %h want 0", ovf); else n_pass++;
        rfbusy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            selwb = 2'b01; rd = 5'(i); res0 = 32'h0000_0200 + 32'(i);
            step();
        end
        rfbusy = 1'b0; selwb = 2'b01; rd = 5'd9; res0 = 32'h0000_0209; #1;
        n_chk++; if (rfwe !== 1'b1 || rfwa !== 5'd1) $display("FAIL fpp_head got we=%h a=%h want we=1 a=1", rfwe, rfwa); else n_pass++;
        step();
        selwb = 2'b00;
        n_chk++; if (full !== 1'b1) $display("FAIL fpp_full got %h want 1", full); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL fpp_ovf got %h want 0", ovf); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (rfwe !== 1'b1 || rfwa !== exp_a[i])
                $display("FAIL fpp_drain%0d got we=%h a=%h want we=1 a=%h", i, rfwe, rfwa, exp_a[i]);
            else n_pass++;
            step();
        end
        n_chk++; if (rfwd !== 32'd0 || rfwe !== 1'b0) $display("FAIL fpp_empty got we=%h d=%h want 0 0", rfwe, rfwd); else n_pass++;
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        rfbusy = 1'b1;
        selwb = 2'b01; rd = 5'd5; res0 = 32'h0000_0011; step();
        selwb = 2'b01; rd = 5'd5; res0 = 32'h0000_0022; step();
        selwb = 2'b00; rs0 = 5'd5; rs1 = 5'd0; #1;
        n_chk++; if (hit0 !== 1'b1) $display("FAIL byp_hit0 got %h want 1", hit0); else n_pass++;
        n_chk++; if (byp0 !== 32'h22) $display("FAIL byp_data0 got %h want 22", byp0); else n_pass++;
        n_chk++; if (hit1 !== 1'b0) $display("FAIL byp_hit1 got %h want 0", hit1); else n_pass++;
        n_chk++; if (byp1 !== 32'h0) $display("FAIL byp_data1 got %h want 0", byp1); else n_pass++;
        rfbusy = 1'b0; #1;
        n_chk++; if (rfwd !== 32'h11) $display("FAIL byp_waw1 got %h want 11", rfwd); else n_pass++;
        step();
        n_chk++; if (rfwd !== 32'h22) $display("FAIL byp_waw2 got %h want 22", rfwd); else n_pass++;
        n_chk++; if (hit0 !== 1'b1) $display("FAIL byp_hit_last got %h want 1", hit0); else n_pass++;
        step();
        n_chk++; if (hit0 !== 1'b0) $display("FAIL byp_hit_empty got %h want 0", hit0); else n_pass++;
    endtask
`endif

    task automatic test_mid_reset();
        do_reset();
        rfbusy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            selwb = 2'b10; rd = 5'(i); res1 = 32'h0000_0300 + 32'(i);
            step();
        end
        selwb = 2'b10; rd = 5'd6; step();
        selwb = 2'b00;
        n_chk++; if (ovf !== 1'b1) $display("FAIL mid_ovf_pre got %h want 1", ovf); else n_pass++;
        do_reset();
        rfbusy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            selwb = 2'b10; rd = 5'(i); res1 = 32'h0000_0400 + 32'(i);
            step();
        end
        rst_n = 1'b0; selwb = 2'b01; rd = 5'd7; res0 = 32'h0000_0777;
        step();
        rst_n = 1'b1; selwb = 2'b00; rfbusy = 1'b0; #1;
        n_chk++; if (rfwe !== 1'b0) $display("FAIL mid_rfwe got %h want 0", rfwe); else n_pass++;
        n_chk++; if (full !== 1'b0) $display("FAIL mid_full got %h want 0", full); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL mid_ovf got %h want 0", ovf); else n_pass++;
        step();
        n_chk++; if (rfwe !== 1'b0) $display("FAIL mid_pending_lost got %h want 0", rfwe); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_filter();
        test_backpressure();
        test_full_push_pop();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
